// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers used by the write- and read-side pointer controllers.
// Pointer helpers work on a zero-extended PTR_MAX-bit vector so that one copy
// serves any pointer width.
package fifo_pkg;

   localparam int FIFO_ADDR_LEN = 5;
   localparam int PTR_MAX       = 32;

   // Binary to Gray; upper zero bits stay zero.
   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < PTR_MAX; i++) r[i] = ^(g >> i);
      return r;
   endfunction

   // Full when the write Gray pointer equals the read Gray pointer with its two
   // MSBs inverted (one lap ahead). pw is the pointer width (ADDR_LEN+1).
   function automatic logic full_cmp(input logic [PTR_MAX-1:0] wr_gray,
                                     input logic [PTR_MAX-1:0] rd_gray,
                                     input int unsigned        pw);
      logic [PTR_MAX-1:0] m;
      m = {{(PTR_MAX-2){1'b0}}, 2'b11} << (pw - 2);
      return wr_gray == (rd_gray ^ m);
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-to-binary converter built as an XOR-prefix chain from the MSB down.
module gray2bin_conv #(
   parameter int W = 6
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Each output bit reduces the Gray bits from itself to the MSB, so no bit
   // feeds back into the same vector.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: binary/Gray write pointers,
// memory write strobe/address, and registered full, almost-full, level and overflow.
module wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_LEN  = FIFO_ADDR_LEN,
   parameter int AF_MARGIN = 4
) (
   input  logic                wr_clk,
   input  logic                wr_rst,
   input  logic                wr_en,
   input  logic [ADDR_LEN:0]   sync_rd_ptr,
   input  logic                ovf_clr,
   output logic                wr_mem_en,
   output logic [ADDR_LEN-1:0] wr_addr,
   output logic [ADDR_LEN:0]   wr_ptr,
   output logic                wr_full,
   output logic                wr_almost_full,
   output logic [ADDR_LEN:0]   wr_level,
   output logic                wr_overflow
);

   localparam int              PW    = ADDR_LEN + 1;
   localparam int              DEPTH = 2 ** ADDR_LEN;
   localparam logic [PW-1:0]   AF_TH = PW'(DEPTH - AF_MARGIN);

   logic          accept;
   logic [PW-1:0] wr_bin, wr_bin_next, wr_gray_next;
   logic [PW-1:0] rd_bin_s, level_next;
   logic          full_val;

   gray2bin_conv #(.W(PW)) u_rd_g2b (
      .gray (sync_rd_ptr),
      .bin  (rd_bin_s)
   );

   // Write strobe only looks at the registered full flag, never at sync_rd_ptr.
   assign accept    = wr_en & ~wr_full;
   assign wr_mem_en = accept;
   assign wr_addr   = wr_bin[ADDR_LEN-1:0];

   assign wr_bin_next  = wr_bin + PW'(accept);
   assign wr_gray_next = PW'(bin2gray(PTR_MAX'(wr_bin_next)));
   assign full_val     = full_cmp(PTR_MAX'(wr_gray_next), PTR_MAX'(sync_rd_ptr), PW);

   // Modulo-2^PW subtraction handles pointer wrap without special cases.
   assign level_next   = wr_bin_next - rd_bin_s;

   // Pointer, flag and level registers all advance together on wr_clk.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wr_bin         <= '0;
         wr_ptr         <= '0;
         wr_full        <= 1'b0;
         wr_almost_full <= 1'b0;
         wr_level       <= '0;
      end else begin
         wr_bin         <= wr_bin_next;
         wr_ptr         <= wr_gray_next;
         wr_full        <= full_val;
         wr_almost_full <= (level_next >= AF_TH);
         wr_level       <= level_next;
      end
   end

   // Sticky overflow: a write attempt while full sets it, and set beats clear.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst)                  wr_overflow <= 1'b0;
      else if (wr_en && wr_full)   wr_overflow <= 1'b1;
      else if (ovf_clr)            wr_overflow <= 1'b0;
   end

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl: directed fill/overflow/almost-full/wrap/reset steps plus a
// randomized producer/consumer phase, checked against a count-based occupancy model.
module tb_wr_ptr_ctrl;

   logic       wr_clk = 1'b0;
   logic       wr_rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [5:0] sync_rd_ptr = '0;
   logic       ovf_clr = 1'b0;
   logic       wr_mem_en;
   logic [4:0] wr_addr;
   logic [5:0] wr_ptr;
   logic       wr_full;
   logic       wr_almost_full;
   logic [5:0] wr_level;
   logic       wr_overflow;

   wr_ptr_ctrl #(.ADDR_LEN(5), .AF_MARGIN(4)) dut (
      .wr_clk         (wr_clk),
      .wr_rst         (wr_rst),
      .wr_en          (wr_en),
      .sync_rd_ptr    (sync_rd_ptr),
      .ovf_clr        (ovf_clr),
      .wr_mem_en      (wr_mem_en),
      .wr_addr        (wr_addr),
      .wr_ptr         (wr_ptr),
      .wr_full        (wr_full),
      .wr_almost_full (wr_almost_full),
      .wr_level       (wr_level),
      .wr_overflow    (wr_overflow)
   );

   always #5 wr_clk = ~wr_clk;

   int errs   = 0;
   int checks = 0;

   // Reference model: total accepted writes and total reads seen, as plain counts.
   int   wcnt, rcnt;
   bit   e_full, e_af, e_ovf;
   logic [5:0] prev_ptr;

   function automatic logic [5:0] gray(input int n);
      logic [5:0] b;
      b = 6'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      int lvl;
      lvl = wcnt - rcnt;
      chk({tag, ".ptr"},   int'(wr_ptr),         int'(gray(wcnt)));
      chk({tag, ".level"}, int'(wr_level),       lvl);
      chk({tag, ".full"},  int'(wr_full),        int'(e_full));
      chk({tag, ".af"},    int'(wr_almost_full), int'(e_af));
      chk({tag, ".ovf"},   int'(wr_overflow),    int'(e_ovf));
      chk({tag, ".lvl_le_32"}, int'(wr_level <= 6'd32), 1);
      chk({tag, ".ptr_1bit"},  int'($countones(wr_ptr ^ prev_ptr) <= 1), 1);
      prev_ptr = wr_ptr;
   endtask

   // One cycle: drive at negedge, check the combinational strobe, clock, check registers.
   task automatic step(input bit wen, input bit adv_rd, input bit clr, input string tag);
      bit acc;
      @(negedge wr_clk);
      wr_en   = wen;
      ovf_clr = clr;
      if (adv_rd && rcnt < wcnt) rcnt++;
      sync_rd_ptr = gray(rcnt);
      #1;
      acc = wen && !e_full;
      chk({tag, ".mem_en"}, int'(wr_mem_en), int'(acc));
      chk({tag, ".addr"},   int'(wr_addr),   wcnt % 32);
      @(posedge wr_clk);
      if (wen && e_full) e_ovf = 1'b1;
      else if (clr)      e_ovf = 1'b0;
      if (acc) wcnt++;
      e_full = (wcnt - rcnt) == 32;
      e_af   = (wcnt - rcnt) >= 28;
      #1;
      chk_regs(tag);
   endtask

   task automatic do_reset();
      @(negedge wr_clk);
      wr_rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; sync_rd_ptr = '0;
      wcnt = 0; rcnt = 0; e_full = 0; e_af = 0; e_ovf = 0;
      #1;
      prev_ptr = '0;
      chk_regs("reset");
      chk("reset.mem_en", int'(wr_mem_en), 0);
      chk("reset.addr",   int'(wr_addr),   0);
      @(negedge wr_clk);
      wr_rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // 1: fill 32 entries with the reader idle.
      for (int i = 0; i < 32; i++) step(1, 0, 0, "fill");
      chk("fill.ptr_const", int'(wr_ptr), int'(6'b110000));
      chk("fill.full_const", int'(wr_full), 1);

      // 2: writes while full are dropped and set the sticky overflow.
      for (int i = 0; i < 3; i++) step(1, 0, 0, "ovf_wr");
      step(0, 0, 0, "ovf_hold");
      step(0, 0, 1, "ovf_clr");
      chk("ovf_clr.const", int'(wr_overflow), 0);
      step(1, 0, 1, "ovf_set_wins");
      step(0, 0, 1, "ovf_clr2");

      // 4: one read frees a slot, one write refills it.
      step(0, 1, 0, "rd1");
      chk("rd1.level_const", int'(wr_level), 31);
      step(1, 0, 0, "refill");
      chk("refill.ptr_const", int'(wr_ptr), int'(gray(33)));

      // 3: almost-full threshold at 28 entries.
      do_reset();
      for (int i = 0; i < 27; i++) step(1, 0, 0, "af_fill");
      chk("af27.af",    int'(wr_almost_full), 0);
      chk("af27.level", int'(wr_level),       27);
      step(1, 0, 0, "af28");
      chk("af28.af",    int'(wr_almost_full), 1);

      // Simultaneous write and read: level unchanged.
      step(1, 1, 0, "wr_rd_same");
      chk("wr_rd_same.level", int'(wr_level), 28);

      // 5: randomized traffic around level ~10, crossing pointer wrap several times.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         int  lvl;
         bit  wen, adv;
         lvl = wcnt - rcnt;
         wen = (lvl < 10) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         adv = (lvl > 10) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step(wen, adv, 1'($urandom_range(0, 7) == 0), "rand");
      end
      chk("rand.wrapped", int'(wcnt > 128), 1);

      // Bursts into full and out again with random reader movement.
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0), 1'b0, "burst");

      // 6: asynchronous reset mid-burst at level 17.
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 0, 0, "pre_rst");
      chk("pre_rst.level", int'(wr_level), 17);
      @(negedge wr_clk);
      wr_en = 1'b1;
      #2 wr_rst = 1'b1;
      wr_en = 1'b0;
      #1;
      chk("async_rst.ptr",   int'(wr_ptr),         0);
      chk("async_rst.full",  int'(wr_full),        0);
      chk("async_rst.af",    int'(wr_almost_full), 0);
      chk("async_rst.level", int'(wr_level),       0);
      chk("async_rst.ovf",   int'(wr_overflow),    0);
      chk("async_rst.addr",  int'(wr_addr),        0);
      chk("async_rst.clk_low", int'(wr_clk), 0);
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
